alu_issue_ctrl: RTL

//   Issue/collect front end for the datapath ALU. Accepts one command per handshake
//   (ALUOp + funct + two signed operands) and decodes it into the 4-bit ALU control code.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_issue_ctrl_if.sv | 43 ++++
 rtl/alu_op_decoder.sv | 33 +++
 rtl/alu_issue_ctrl.sv | 110 +++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue controller: ALU control codes, ALUOp/funct
// fields and the controller FSM states.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'h0;
    localparam logic [3:0] ALU_OR  = 4'h1;
    localparam logic [3:0] ALU_ADD = 4'h2;
    localparam logic [3:0] ALU_SUB = 4'h6;
    localparam logic [3:0] ALU_SLT = 4'h7;
    localparam logic [3:0] ALU_NOR = 4'hC;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Command, ALU and response channels of the ALU issue controller.
// slave = controller side, master = command source / ALU / response sink.
interface alu_issue_ctrl_if #(
    parameter int DATA_W = 48,
    parameter int CNT_W  = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_aluop;
    logic [5:0]        cmd_funct;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic              cmd_fwd_a;

    logic [3:0]        alu_ctrl;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;
    logic              rsp_err;
    logic [CNT_W-1:0]  op_count;
    logic [CNT_W-1:0]  err_count;

    modport slave (
        input  cmd_valid, cmd_aluop, cmd_funct, cmd_a, cmd_b, cmd_fwd_a,
        input  alu_result, alu_zero, rsp_ready,
        output cmd_ready, alu_ctrl, alu_a, alu_b,
        output rsp_valid, rsp_result, rsp_zero, rsp_err, op_count, err_count
    );

    modport master (
        output cmd_valid, cmd_aluop, cmd_funct, cmd_a, cmd_b, cmd_fwd_a,
        output alu_result, alu_zero, rsp_ready,
        input  cmd_ready, alu_ctrl, alu_a, alu_b,
        input  rsp_valid, rsp_result, rsp_zero, rsp_err, op_count, err_count
    );

endinterface

// File: rtl/alu_op_decoder.sv
// Combinational {ALUOp, funct} to 4-bit ALU control decode with illegal-funct flag.
module alu_op_decoder
    import alu_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [5:0] funct_i,
    output logic [3:0] ctrl_o,
    output logic       illegal_o
);

    always_comb begin
        ctrl_o    = ALU_ADD;
        illegal_o = 1'b0;
        case (aluop_i)
            ALUOP_ADD: ctrl_o = ALU_ADD;
            ALUOP_SUB: ctrl_o = ALU_SUB;
            ALUOP_OR:  ctrl_o = ALU_OR;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FUNCT_ADD: ctrl_o = ALU_ADD;
                    FUNCT_SUB: ctrl_o = ALU_SUB;
                    FUNCT_AND: ctrl_o = ALU_AND;
                    FUNCT_OR:  ctrl_o = ALU_OR;
                    FUNCT_NOR: ctrl_o = ALU_NOR;
                    FUNCT_SLT: ctrl_o = ALU_SLT;
                    default:   illegal_o = 1'b1;
                endcase
            end
            default: ctrl_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/collect front end for the external combinational ALU.
// Optional operand-A forwarding from the last good result: define ALU_BYPASS_EN.
//
// state   | meaning
// IDLE    | ready for a command
// EXEC    | registered ctrl/operands on alu_*, capture result at end of cycle
// RESP    | response held on rsp_* until consumed
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = 48,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    alu_issue_ctrl_if.slave  bus
);

    state_e            state_q, state_d;
    logic [3:0]        dec_ctrl;
    logic              dec_illegal;
    logic              accept, capture;

    logic [3:0]        ctrl_q;
    logic [DATA_W-1:0] a_q, b_q, res_q, a_sel;
    logic              zero_q, err_q;
    logic [CNT_W-1:0]  op_cnt_q, err_cnt_q;

    alu_op_decoder u_dec (
        .aluop_i   (bus.cmd_aluop),
        .funct_i   (bus.cmd_funct),
        .ctrl_o    (dec_ctrl),
        .illegal_o (dec_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.cmd_valid) state_d = dec_illegal ? ST_RESP : ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // cmd_ready is gated by rst so every output reads 0 while reset is held
    always_comb begin
        bus.cmd_ready = (state_q == ST_IDLE) && !rst;
        bus.rsp_valid = (state_q == ST_RESP);
        accept        = (state_q == ST_IDLE) && bus.cmd_valid;
        capture       = (state_q == ST_EXEC);
    end

`ifdef ALU_BYPASS_EN
    logic [DATA_W-1:0] last_good_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          last_good_q <= '0;
        else if (capture) last_good_q <= bus.alu_result;
    end

    assign a_sel = bus.cmd_fwd_a ? last_good_q : bus.cmd_a;
`else
    logic unused_fwd;
    assign unused_fwd = bus.cmd_fwd_a;
    assign a_sel      = bus.cmd_a;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            zero_q    <= 1'b0;
            err_q     <= 1'b0;
            op_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else if (accept && !dec_illegal) begin
            ctrl_q <= dec_ctrl;
            a_q    <= a_sel;
            b_q    <= bus.cmd_b;
        end else if (accept) begin
            res_q     <= '0;
            zero_q    <= 1'b0;
            err_q     <= 1'b1;
            err_cnt_q <= err_cnt_q + CNT_W'(1);
        end else if (capture) begin
            res_q    <= bus.alu_result;
            zero_q   <= bus.alu_zero;
            err_q    <= 1'b0;
            op_cnt_q <= op_cnt_q + CNT_W'(1);
        end
    end

    assign bus.alu_ctrl   = ctrl_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.rsp_result = res_q;
    assign bus.rsp_zero   = zero_q;
    assign bus.rsp_err    = err_q;
    assign bus.op_count   = op_cnt_q;
    assign bus.err_count  = err_cnt_q;

endmodule
